// File: rtl/parity_arb_pkg.sv
// Shared types, default sizes and the round-robin winner search for parity_check_arbiter.
package parity_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_REQ   = 16;

  // First set request bit at or above ptr, wrapping modulo num_req.
  function automatic logic [3:0] rr_winner(input logic [15:0] req, input logic [3:0] ptr,
                                           input int num_req);
    logic [3:0] win;
    logic       found;
    int         idx;
    win   = 4'd0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % num_req;
      if (!found && (k < num_req) && req[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/even_or_odd.sv
// Shared classifier: flags an operand as even.
module even_or_odd #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] number,
  output logic             even_odd
);

  assign even_odd = ~number[0];

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ requesters through one even_or_odd classifier,
// with tagged results and saturating even/odd tallies.
module parity_check_arbiter
  import parity_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     cnt_clr,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_even,
  output logic [CNT_W-1:0]         even_count,
  output logic [CNT_W-1:0]         odd_count
);

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, win_d;
  logic [WIDTH-1:0]   num_q, num_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               rsp_valid_q, rsp_even_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [CNT_W-1:0]   even_cnt_q, odd_cnt_q;
  logic               even_odd_s;

  even_or_odd #(.WIDTH(WIDTH)) u_classifier (
    .number   (num_q),
    .even_odd (even_odd_s)
  );

  always_comb begin
    win_d = ID_W'(rr_winner(16'(req), 4'(ptr_q), NUM_REQ));
    num_d = req_data[int'(win_d)*WIDTH +: WIDTH];
    gnt_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
    if (win_d == ID_W'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_d + ID_W'(1);
    end
  end

  // req is only sampled in IDLE, so a requester dropping req at the end of its grant is never re-granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      num_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_even_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          if (|req) begin
            gnt_q   <= gnt_d;
            id_q    <= win_d;
            num_q   <= num_d;
            ptr_q   <= ptr_d;
            state_q <= BUSY;
          end else begin
            gnt_q <= '0;
          end
        end
        BUSY: begin
          gnt_q       <= '0;
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_even_q  <= even_odd_s;
          state_q     <= IDLE;
        end
        default: begin
          gnt_q       <= '0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Clear has priority over a response landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      even_cnt_q <= '0;
      odd_cnt_q  <= '0;
    end else if (cnt_clr) begin
      even_cnt_q <= '0;
      odd_cnt_q  <= '0;
    end else if (rsp_valid_q) begin
      if (rsp_even_q && (even_cnt_q != {CNT_W{1'b1}})) begin
        even_cnt_q <= even_cnt_q + CNT_W'(1);
      end else if (!rsp_even_q && (odd_cnt_q != {CNT_W{1'b1}})) begin
        odd_cnt_q <= odd_cnt_q + CNT_W'(1);
      end else begin
        even_cnt_q <= even_cnt_q;
      end
    end else begin
      even_cnt_q <= even_cnt_q;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_even   = rsp_even_q;
  assign even_count = even_cnt_q;
  assign odd_count  = odd_cnt_q;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed plus randomized bench for parity_check_arbiter against a transaction-level reference model.
module tb_parity_check_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int CW = 4;
  localparam int IW = $clog2(N);
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic           cnt_clr = 1'b0;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic           rsp_even;
  logic [CW-1:0]  even_count, odd_count;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit m_busy;
  int m_ptr, m_num, m_id;
  int e_gnt, e_valid, e_id, e_even, e_ec, e_oc;

  parity_check_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .cnt_clr(cnt_clr),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_even(rsp_even),
    .even_count(even_count), .odd_count(odd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_num = 0; m_id = 0;
    e_gnt = 0; e_valid = 0; e_id = 0; e_even = 0; e_ec = 0; e_oc = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    if (cnt_clr) begin
      e_ec = 0; e_oc = 0;
    end else if (e_valid != 0) begin
      if (e_even != 0) e_ec = (e_ec < CMAX) ? e_ec + 1 : CMAX;
      else             e_oc = (e_oc < CMAX) ? e_oc + 1 : CMAX;
    end
    if (m_busy) begin
      e_gnt = 0; e_valid = 1; e_id = m_id; e_even = (m_num % 2 == 0) ? 1 : 0;
      m_busy = 0;
    end else begin
      e_valid = 0; e_gnt = 0;
      if (req != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (req[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
        end
        e_gnt  = 1 << m_id;
        m_num  = int'(req_data[m_id*W +: W]);
        m_ptr  = (m_id + 1) % N;
        m_busy = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("gnt", int'(gnt), e_gnt);
    chk("rsp_valid", int'(rsp_valid), e_valid);
    chk("even_count", int'(even_count), e_ec);
    chk("odd_count", int'(odd_count), e_oc);
    chk("gnt_rsp_exclusive", int'((gnt != '0) && rsp_valid), 0);
    if (e_valid != 0) begin
      chk("rsp_id", int'(rsp_id), e_id);
      chk("rsp_even", int'(rsp_even), e_even);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_even", int'(rsp_even), 0);
    chk("rst_counts", int'({even_count, odd_count}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_data(input int i, input int v);
    req_data[i*W +: W] = W'(v);
  endtask

  initial begin
    do_reset();

    // single request with an even operand
    req = 4'b0001; set_data(0, 6);
    cycle(); chk("single_gnt", int'(gnt), 1);
    req = 4'b0000;
    cycle(); chk("single_valid", int'(rsp_valid), 1);
    chk("single_id", int'(rsp_id), 0); chk("single_even", int'(rsp_even), 1);
    cycle(); chk("single_even_count", int'(even_count), 1);
    cycle(); chk("idle_gnt", int'(gnt), 0);

    // all four requesters, each dropping after its grant
    do_reset();
    req = 4'b1111; set_data(0, 3); set_data(1, 4); set_data(2, 7); set_data(3, 8);
    for (int k = 0; k < N; k++) begin
      cycle(); chk("all4_gnt", int'(gnt), 1 << k);
      req[k] = 1'b0;
      cycle(); chk("all4_even", int'(rsp_even), k % 2);
    end
    cycle(); chk("all4_even_cnt", int'(even_count), 2); chk("all4_odd_cnt", int'(odd_count), 2);
    req = 4'b1111;
    cycle(); chk("ptr_wrap_gnt", int'(gnt), 1);
    req = 4'b0000;
    cycle(); cycle();

    // fairness with two persistent requesters
    do_reset();
    req = 4'b0101; set_data(0, 1); set_data(2, 2);
    for (int k = 0; k < 6; k++) begin
      cycle(); chk("fair_gnt", int'(gnt), (k % 2 == 0) ? 1 : 4);
      cycle();
    end
    req = 4'b0000;
    cycle(); cycle();

    // operand sweep on requester 1
    do_reset();
    for (int v = 0; v < 16; v++) begin
      req = 4'b0010; set_data(1, v);
      cycle(); req = 4'b0000;
      cycle(); chk("sweep_even", int'(rsp_even), (v % 2 == 0) ? 1 : 0);
      chk("sweep_id", int'(rsp_id), 1);
    end
    cycle(); chk("sweep_even_cnt", int'(even_count), 8); chk("sweep_odd_cnt", int'(odd_count), 8);

    // saturation of the even tally, then clear colliding with a response
    do_reset();
    for (int v = 0; v < CMAX + 2; v++) begin
      req = 4'b0100; set_data(2, 2 * v);
      cycle(); req = 4'b0000;
      cycle();
    end
    cycle(); chk("sat_even_cnt", int'(even_count), CMAX);
    req = 4'b1000; set_data(3, 5);
    cycle(); req = 4'b0000;
    cycle(); chk("clr_rsp_valid", int'(rsp_valid), 1);
    cnt_clr = 1'b1;
    cycle(); cnt_clr = 1'b0;
    chk("clr_even_cnt", int'(even_count), 0); chk("clr_odd_cnt", int'(odd_count), 0);

    // reset in the middle of BUSY
    req = 4'b0100; set_data(2, 9);
    cycle(); chk("midbusy_gnt", int'(gnt), 4);
    req = 4'b0000;
    do_reset();
    cycle(); chk("midbusy_no_rsp", int'(rsp_valid), 0);
    req = 4'b1111;
    cycle(); chk("post_reset_gnt", int'(gnt), 1);
    req = 4'b0000;
    cycle(); cycle();

    // randomized traffic obeying the requester contract
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (e_gnt[i]) begin
          req[i] = 1'($urandom_range(0, 3) == 0);
          set_data(i, int'($urandom_range(0, 15)));
        end else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
          req[i] = 1'b1;
          set_data(i, int'($urandom_range(0, 15)));
        end
      end
      cnt_clr = 1'($urandom_range(0, 40) == 0);
      cycle();
    end
    cnt_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_check_arbiter.md
# parity_check_arbiter

Round-robin arbiter and sequencer sharing a single `even_or_odd` classifier among `NUM_REQ` requesters. Each requester presents a number with a level request. The block grants one requester at a time and latches its number into the shared classifier. It returns a tagged even/odd result one cycle later and keeps saturating even/odd tallies. It sits between the client request ports and the one classifier instance.

## Interface
- `NUM_REQ`, default 4: number of requesters; 2..16.
- `WIDTH`, default 4: operand width; matches the `even_or_odd` `number` port.
- `CNT_W`, default 16: width of the tally counters.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, NUM_REQ: level request per requester.
- `req_data`, input, NUM_REQ*WIDTH: operand per requester; requester i is at bits `[i*WIDTH +: WIDTH]`.
- `cnt_clr`, input, 1: synchronous clear of both tallies.
- `gnt`, output, NUM_REQ: registered one-hot grant, high for exactly one cycle.
- `rsp_valid`, output, 1: one-cycle result strobe.
- `rsp_id`, output, $clog2(NUM_REQ): index of the requester this result belongs to.
- `rsp_even`, output, 1: 1 = operand even, 0 = odd.
- `even_count`, output, CNT_W: saturating count of even results.
- `odd_count`, output, CNT_W: saturating count of odd results.

## Operation
- FSM states:
  - IDLE: sample `req`.
  - BUSY: classify the latched operand.
- IDLE with `req` != 0:
  - Choose the winner as the first set bit at or above `ptr`, wrapping modulo NUM_REQ.
  - Latch that requester's `req_data` into `num_q`.
  - Register `gnt` = one-hot(winner) and `id_q` = winner.
  - Set `ptr` = winner+1, wrapping NUM_REQ-1 to 0. Go to BUSY.
- IDLE with `req` == 0: stay in IDLE; `gnt` = 0; `ptr` unchanged.
- BUSY:
  - Register `rsp_valid` = 1, `rsp_id` = `id_q`, and `rsp_even` from the `even_or_odd` output driven by `num_q`.
  - `even_odd` = ~`num_q`[0].
  - Clear `gnt` and return to IDLE.
- Tallies:
  - On `rsp_valid` high, increment the matching tally, saturating at 2^CNT_W-1.
  - `cnt_clr` forces both tallies to 0 on that edge.
  - If `cnt_clr` and a response update fall on the same edge, clear wins and that response is not counted.
- Requester contract:
  - Hold `req` and `req_data` stable until `gnt[i]` is seen high.
  - Drop `req` at the edge that ends the grant cycle, unless another transaction is wanted.
  - Keeping `req` high re-enters arbitration, but round-robin gives every other pending requester a turn first.
- Reset, including mid-BUSY:
  - State = IDLE, `ptr` = 0.
  - `gnt` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_even` = 0, both tallies = 0.
  - An in-flight transaction is dropped with no response.

## Timing
- Arbitration edge E0 (IDLE, `req` != 0): `gnt` is high during cycle E0→E1.
- Edge E1: `gnt` falls, and `rsp_valid`/`rsp_id`/`rsp_even` are high during cycle E1→E2.
- The tallies reflect the response at edge E2.
- Request-to-result latency is 2 edges. Peak throughput is one grant per 2 cycles.
- The next arbitration occurs at E2. Because the FSM does not sample `req` in BUSY, a requester dropping `req` at E1 can never be double-granted.
- `gnt` and `rsp_valid` are mutually exclusive in any cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `parity_arb_pkg`:
  - State enum {IDLE, BUSY}.
  - Default WIDTH = 4 and CNT_W = 16 constants.
  - A function returning the round-robin winner index from `req` and `ptr`.
- Sub-module: one instance of the existing `even_or_odd`, with `num_q` as `number` and `even_odd` feeding `rsp_even`.
- The arbiter, FSM and tallies are all in `parity_check_arbiter`.

## Test plan
- Single request: `req`=0001 with data 6 → `gnt`=0001 for one cycle, then `rsp_valid` with `rsp_id`=0, `rsp_even`=1; `even_count`=1.
- All four requesters held with data 3, 4, 7, 8, each dropping `req` after its grant → grants 0, 1, 2, 3 on every other cycle; `rsp_even` = 0, 1, 0, 1; final counts 2/2; `ptr` wraps to 0.
- Fairness: requesters 0 and 2 always requesting → grants alternate 0, 2, 0, 2; never 0, 0.
- Sweep: one requester presents 0..15 → 8 even, 8 odd. Each `rsp_even` equals ~bit0, e.g. 15 gives 0.
- Saturation and clear:
  - Force `even_count` to 0xFFFF, then send an even operand → count holds at 0xFFFF.
  - Assert `cnt_clr` on the same edge as a response → both tallies are 0.
- Reset mid-BUSY: assert `rst` in the cycle after a grant → no `rsp_valid`, all outputs 0, and the next grant starts from requester 0.
